// File: rtl/wb_cmd_sequencer.sv
// wb_cmd_sequencer: FIFO-buffered command feeder for the CPU-stub Wishbone master.
// Optional watchdog: define WB_SEQ_TIMEOUT_EN to enable the TMO-cycle timeout.
module wb_cmd_sequencer #(
    parameter int dw    = 32,
    parameter int aw    = 32,
    parameter int DEPTH = 4,
    parameter int TMO   = 255
) (
    input  logic                     wb_clk,
    input  logic                     wb_rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [aw-1:0]            cmd_addr,
    input  logic [3:0]               cmd_sel,
    input  logic                     cmd_we,
    input  logic [dw-1:0]            cmd_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [dw-1:0]            rsp_data,
    output logic                     rsp_we,
    output logic                     rsp_tmo,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     start,
    output logic [aw-1:0]            address,
    output logic [3:0]               selection,
    output logic                     write,
    output logic [dw-1:0]            data_wr,
    input  logic                     active,
    input  logic [dw-1:0]            data_rd
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and at least 2");
    end
    if (TMO < 1 || TMO > 65535) begin : g_bad_tmo
        $error("TMO must be in 1..65535");
    end

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACT, WAIT_DONE, RESP} state_t;

    state_t          r_state;
    logic [aw-1:0]   r_mem_addr [DEPTH];
    logic [3:0]      r_mem_sel  [DEPTH];
    logic            r_mem_we   [DEPTH];
    logic [dw-1:0]   r_mem_data [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_start;
    logic [aw-1:0]   r_address;
    logic [3:0]      r_selection;
    logic            r_write;
    logic [dw-1:0]   r_data_wr;
    logic            r_rsp_valid;
    logic [dw-1:0]   r_rsp_data;
    logic            r_rsp_we;
    logic            w_push;
    logic            w_pop;
    logic            w_bus_free;

`ifdef WB_SEQ_TIMEOUT_EN
    logic [15:0]     r_tmo_cnt;
    logic            r_rsp_tmo;
    // after a timeout the master may still be busy; hold the next command until it lets go
    assign w_bus_free = !active;
    assign rsp_tmo    = r_rsp_tmo;
`else
    assign w_bus_free = 1'b1;
    assign rsp_tmo    = 1'b0;
`endif

    assign cmd_ready  = (r_count != CW'(DEPTH));
    assign w_push     = cmd_valid && cmd_ready;
    assign w_pop      = (r_state == IDLE) && (r_count != '0) && !r_rsp_valid && w_bus_free;
    assign fifo_count = r_count;
    assign start      = r_start;
    assign address    = r_address;
    assign selection  = r_selection;
    assign write      = r_write;
    assign data_wr    = r_data_wr;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_we     = r_rsp_we;

    // command storage; contents are don't-care until pushed, so no reset needed
    always_ff @(posedge wb_clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= cmd_addr;
            r_mem_sel[r_wr_ptr]  <= cmd_sel;
            r_mem_we[r_wr_ptr]   <= cmd_we;
            r_mem_data[r_wr_ptr] <= cmd_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-2 depth
    always_ff @(posedge wb_clk) begin
        if (!wb_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= w_push ? r_wr_ptr + 1'b1 : r_wr_ptr;
            r_rd_ptr <= w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
            r_count  <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // command FSM driving the master and the response port, all outputs registered
    always_ff @(posedge wb_clk) begin
        if (!wb_rst) begin
            r_state     <= IDLE;
            r_start     <= 1'b0;
            r_address   <= '0;
            r_selection <= '0;
            r_write     <= 1'b0;
            r_data_wr   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_we    <= 1'b0;
`ifdef WB_SEQ_TIMEOUT_EN
            r_tmo_cnt   <= '0;
            r_rsp_tmo   <= 1'b0;
`endif
        end else begin
            r_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_address   <= r_mem_addr[r_rd_ptr];
                        r_selection <= r_mem_sel[r_rd_ptr];
                        r_write     <= r_mem_we[r_rd_ptr];
                        r_data_wr   <= r_mem_data[r_rd_ptr];
                        r_start     <= 1'b1;
                        r_state     <= ISSUE;
`ifdef WB_SEQ_TIMEOUT_EN
                        r_tmo_cnt   <= '0;
`endif
                    end
                end
                ISSUE: r_state <= WAIT_ACT;
                WAIT_ACT, WAIT_DONE: begin
`ifdef WB_SEQ_TIMEOUT_EN
                    r_tmo_cnt <= r_tmo_cnt + 16'd1;
                    if (r_tmo_cnt == 16'(TMO - 1)) begin
                        r_rsp_data  <= '0;
                        r_rsp_we    <= r_write;
                        r_rsp_tmo   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else
`endif
                    if (r_state == WAIT_ACT) begin
                        if (active) r_state <= WAIT_DONE;
                    end else if (!active) begin
                        r_rsp_data  <= data_rd;
                        r_rsp_we    <= r_write;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
`ifdef WB_SEQ_TIMEOUT_EN
                        r_rsp_tmo   <= 1'b0;
`endif
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_cmd_sequencer.sv
// tb_wb_cmd_sequencer: directed checks of wb_cmd_sequencer against a simple master stub.
module tb_wb_cmd_sequencer;
    logic        wb_clk = 1'b0;
    logic        wb_rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [3:0]  cmd_sel = '0;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_we;
    logic        rsp_tmo;
    logic [2:0]  fifo_count;
    logic        start;
    logic [31:0] address;
    logic [3:0]  selection;
    logic        write;
    logic [31:0] data_wr;
    logic        active;
    logic [31:0] data_rd;

    int          n_checks = 0;
    int          n_fail = 0;
    int          n_start = 0;
    int          slave_mode = 1;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [3:0]  st_sel = '0;
    logic        st_we = 1'b0;

    wb_cmd_sequencer #(.dw(32), .aw(32), .DEPTH(4), .TMO(8)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_sel(cmd_sel), .cmd_we(cmd_we), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_we(rsp_we), .rsp_tmo(rsp_tmo), .fifo_count(fifo_count),
        .start(start), .address(address), .selection(selection), .write(write),
        .data_wr(data_wr), .active(active), .data_rd(data_rd)
    );

    always #5 wb_clk = ~wb_clk;

    function automatic logic [31:0] rd_map(input logic [31:0] a);
        return (a == 32'h20) ? 32'h1234_5678 : (32'hC0DE_0000 | a);
    endfunction

    // record every start pulse and the command it launched
    always @(posedge wb_clk) begin
        if (start === 1'b1) begin
            n_start = n_start + 1;
            st_addr = address;
            st_data = data_wr;
            st_sel  = selection;
            st_we   = write;
        end
    end

    // master stub: mode 1 busy for two cycles, mode 2 busy until released, mode 0 never acks
    initial begin
        active  = 1'b0;
        data_rd = '0;
        forever begin
            @(posedge wb_clk);
            if (start === 1'b1 && slave_mode != 0) begin
                #1 active = 1'b1;
                if (slave_mode == 1) repeat (2) @(posedge wb_clk);
                else wait (slave_mode != 2);
                #1 data_rd = rd_map(address);
                active = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [3:0] s, input logic we, input logic [31:0] d);
        cmd_addr  = a;
        cmd_sel   = s;
        cmd_we    = we;
        cmd_data  = d;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int k = 0;
        while (rsp_valid !== 1'b1 && k < 60) begin
            tick();
            k++;
        end
        if (rsp_valid !== 1'b1) check("rsp_wait_expired", 0, 1);
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        int k;
        int s0;
        logic stable;
        logic [31:0] d0;

        // reset held three cycles
        repeat (3) @(posedge wb_clk);
        #1;
        check("rst_start", start, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_tmo", rsp_tmo, 0);
        check("rst_rsp_we", rsp_we, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_address", address, 0);
        check("rst_selection", selection, 0);
        check("rst_write", write, 0);
        check("rst_data_wr", data_wr, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        wb_rst = 1'b1;
        tick();

        // single write
        push(32'h10, 4'hF, 1'b1, 32'hDEAD_BEEF);
        wait_rsp();
        check("wr_start_count", n_start, 1);
        check("wr_address", st_addr, 32'h10);
        check("wr_data_wr", st_data, 32'hDEAD_BEEF);
        check("wr_sel", st_sel, 4'hF);
        check("wr_write", st_we, 1);
        check("wr_write_held", write, 1);
        check("wr_rsp_we", rsp_we, 1);
        check("wr_rsp_data", rsp_data, 32'hC0DE_0010);
        check("wr_rsp_tmo", rsp_tmo, 0);
        ack();
        check("wr_rsp_cleared", rsp_valid, 0);

        // single read
        push(32'h20, 4'h3, 1'b0, 32'h0);
        wait_rsp();
        check("rd_start_count", n_start, 2);
        check("rd_address", st_addr, 32'h20);
        check("rd_write", st_we, 0);
        check("rd_rsp_data", rsp_data, 32'h1234_5678);
        check("rd_rsp_we", rsp_we, 0);
        ack();

        // five commands into a four-deep FIFO with the response port stalled
        for (int i = 0; i < 5; i++) begin
            check("fill_ready", cmd_ready, 1);
            push(32'h40 + 32'(4 * i), 4'hF, i[0], 32'(i));
        end
        check("full_count", fifo_count, 4);
        check("full_ready", cmd_ready, 0);
        push(32'hBAD, 4'h1, 1'b1, 32'hBAD);
        check("full_no_overwrite_count", fifo_count, 4);

        // hold rsp_ready low for ten cycles
        wait_rsp();
        d0 = rsp_data;
        s0 = n_start;
        stable = 1'b1;
        repeat (10) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_we !== 1'b0) stable = 1'b0;
        end
        check("stall_stable", stable, 1);
        check("stall_no_start", n_start, s0);
        check("q0_rsp_data", rsp_data, 32'hC0DE_0040);
        check("q0_rsp_we", rsp_we, 0);
        ack();
        k = 0;
        while (start !== 1'b1 && k < 2) begin
            tick();
            k++;
        end
        check("restart_within_2", start, 1);
        for (int i = 1; i < 5; i++) begin
            wait_rsp();
            check("q_rsp_data", rsp_data, 32'hC0DE_0040 + 32'(4 * i));
            check("q_rsp_we", rsp_we, 64'(i[0]));
            ack();
        end
        check("drain_count", fifo_count, 0);
        check("drain_ready", cmd_ready, 1);
        check("drain_start_total", n_start, 7);

`ifdef WB_SEQ_TIMEOUT_EN
        // master never acknowledges: watchdog answers instead
        slave_mode = 0;
        push(32'h60, 4'hF, 1'b0, 32'h0);
        wait_rsp();
        check("tmo_flag", rsp_tmo, 1);
        check("tmo_rsp_data", rsp_data, 0);
        ack();
        slave_mode = 1;
        push(32'h64, 4'hF, 1'b0, 32'h0);
        wait_rsp();
        check("tmo_clear", rsp_tmo, 0);
        check("tmo_next_data", rsp_data, 32'hC0DE_0064);
        ack();
`endif

        // reset while the master is busy; queued command must be lost
        slave_mode = 2;
        push(32'h70, 4'hF, 1'b1, 32'h7);
        push(32'h74, 4'hF, 1'b1, 32'h8);
        repeat (3) tick();
        check("busy_active", active, 1);
        wb_rst = 1'b0;
        tick();
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_start", start, 0);
        check("midrst_address", address, 0);
        check("midrst_write", write, 0);
        check("midrst_count", fifo_count, 0);
        check("midrst_ready", cmd_ready, 1);
        wb_rst = 1'b1;
        slave_mode = 0;
        s0 = n_start;
        repeat (6) tick();
        check("midrst_no_start", n_start, s0);
        check("midrst_no_rsp", rsp_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
